// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_pkg                                                          |
// | Shared constants, door state type and popcount helper for the        |
// | 4-slot parking lot controller.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int CAP_W     = 3;

  typedef enum logic [0:0] {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } door_state_e;

  function automatic logic [CAP_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [CAP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + CAP_W'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_fsm_if                                                       |
// | Sensor-side inputs and gate/display outputs of the lot controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface parking_fsm_if;
  import parking_pkg::*;

  logic                 entry_signal;
  logic                 exit_signal;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 is_open;
  logic                 is_full;
  logic [NUM_SLOTS-1:0] spots;
  logic [CAP_W-1:0]     capacity;
  logic [SLOT_W-1:0]    location;

  modport master (
    output entry_signal, exit_signal, exit_slot,
    input  is_open, is_full, spots, capacity, location
  );

  modport slave (
    input  entry_signal, exit_signal, exit_slot,
    output is_open, is_full, spots, capacity, location
  );

endinterface
`default_nettype wire

// File: rtl/parking_fsm_lowest_free_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lowest_free_enc                                                      |
// | Priority encoder: index of the lowest set bit of a free-slot mask.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lowest_free_enc
  import parking_pkg::*;
(
  input  wire logic [NUM_SLOTS-1:0] free_i,
  output logic      [SLOT_W-1:0]    idx_o,
  output logic                      found_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o   = SLOT_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_fsm                                                          |
// | 4-slot parking lot controller: occupancy, slot assignment, door.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module parking_fsm
  import parking_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  parking_fsm_if.slave  bus
);

  door_state_e          state_q, state_d;
  logic [NUM_SLOTS-1:0] spots_q, spots_d;
  logic [CAP_W-1:0]     capacity_q, capacity_d;
  logic [SLOT_W-1:0]    location_q, location_d;
  logic                 full_q, full_d;

  logic                 w_exit_ok;
  logic                 w_entry_ok;
  logic [NUM_SLOTS-1:0] w_after_exit;
  logic [SLOT_W-1:0]    w_free_idx;
  logic                 w_free_found;

  // Exit is resolved first so an entry in the same cycle sees the vacated slot.
  always_comb begin
    w_after_exit = spots_q;
    w_exit_ok    = bus.exit_signal && spots_q[bus.exit_slot];
    if (w_exit_ok) begin
      w_after_exit[bus.exit_slot] = 1'b0;
    end
  end

  lowest_free_enc u_enc (
    .free_i  (~w_after_exit),
    .idx_o   (w_free_idx),
    .found_o (w_free_found)
  );

  always_comb begin
    w_entry_ok = bus.entry_signal && w_free_found;
    spots_d    = w_after_exit;
    location_d = location_q;
    if (w_entry_ok) begin
      spots_d[w_free_idx] = 1'b1;
      location_d          = w_free_idx;
    end
    capacity_d = CAP_W'(NUM_SLOTS) - popcount(spots_d);
    full_d     = (capacity_d == '0);
    state_d    = (w_exit_ok || w_entry_ok) ? OPEN : CLOSED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLOSED;
      spots_q    <= '0;
      capacity_q <= CAP_W'(NUM_SLOTS);
      location_q <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      spots_q    <= spots_d;
      capacity_q <= capacity_d;
      location_q <= location_d;
      full_q     <= full_d;
    end
  end

  assign bus.is_open  = (state_q == OPEN);
  assign bus.is_full  = full_q;
  assign bus.spots    = spots_q;
  assign bus.capacity = capacity_q;
  assign bus.location = location_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parking_fsm                                                       |
// | Directed self-checking bench for the parking lot controller.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_parking_fsm;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  parking_fsm_if pif();

  parking_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sp, input logic [2:0] cap,
                           input logic [1:0] loc, input logic op, input logic full);
    check({tag, ".spots"},    pif.spots,           sp);
    check({tag, ".capacity"}, {1'b0, pif.capacity}, {1'b0, cap});
    check({tag, ".location"}, {2'b0, pif.location}, {2'b0, loc});
    check({tag, ".is_open"},  {3'b0, pif.is_open},  {3'b0, op});
    check({tag, ".is_full"},  {3'b0, pif.is_full},  {3'b0, full});
  endtask

  task automatic step(input logic en, input logic ex, input logic [1:0] sl);
    @(negedge clk);
    pif.entry_signal = en;
    pif.exit_signal  = ex;
    pif.exit_slot    = sl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pif.entry_signal = 1'b0;
    pif.exit_signal  = 1'b0;
    pif.exit_slot    = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset", 4'b0000, 3'd4, 2'd0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 2'd0); check_all("entry0", 4'b0001, 3'd3, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0); check_all("entry1", 4'b0011, 3'd2, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0); check_all("entry2", 4'b0111, 3'd1, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0); check_all("entry3", 4'b1111, 3'd0, 2'd3, 1'b1, 1'b1);

    step(1'b1, 1'b0, 2'd0); check_all("entry_full", 4'b1111, 3'd0, 2'd3, 1'b0, 1'b1);

    step(1'b0, 1'b1, 2'd1); check_all("exit1", 4'b1101, 3'd1, 2'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'd1); check_all("exit1_again", 4'b1101, 3'd1, 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0); check_all("idle", 4'b1101, 3'd1, 2'd3, 1'b0, 1'b0);

    step(1'b1, 1'b0, 2'd0); check_all("refill1", 4'b1111, 3'd0, 2'd1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd2); check_all("swap2", 4'b1111, 3'd0, 2'd2, 1'b1, 1'b1);
    step(1'b0, 1'b0, 2'd0); check_all("close", 4'b1111, 3'd0, 2'd2, 1'b0, 1'b1);

    step(1'b0, 1'b1, 2'd3); check_all("exit3", 4'b0111, 3'd1, 2'd2, 1'b1, 1'b0);
    // Exit of slot 0 frees it, and the simultaneous entry takes it back.
    step(1'b1, 1'b1, 2'd0); check_all("swap0", 4'b0111, 3'd1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd3); check_all("entry_bad_exit", 4'b1111, 3'd0, 2'd3, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'd3); check_all("exit3b", 4'b0111, 3'd1, 2'd3, 1'b1, 1'b0);

    pif.entry_signal = 1'b0;
    pif.exit_signal  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 3'd4, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 2'd0); check_all("post_reset", 4'b0000, 3'd4, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
